// File: rtl/vm_mask_sequencer.sv
//------------------------------------------------------------------------------
// Module   : vm_mask_sequencer
// Desc     : Mask-file sequencer that pops FIFO entries onto per-channel PS/VAT words.
//            Optional build macro VM_UNDERFLOW_COUNT_EN adds a saturating underflow counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vm_mask_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int PS_W       = 6,
  parameter int VAT_W      = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ctrl_rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          fast_clk_div,
  input  logic [CNT_W-1:0]          slow_clk_div,
  input  logic [CNT_W-1:0]          pulse_cnt,
  input  logic [CNT_W-1:0]          row_length,
  input  logic [CNT_W-1:0]          row_valid_length,
  input  logic [CNT_W-1:0]          file_length,
  input  logic [NUM_CH-1:0]         active_modes,
  input  logic [NUM_CH-1:0]         phase_idle_modes,
  input  logic [NUM_CH-1:0]         atten_idle_modes,
  input  logic [NUM_CH*(PS_W+VAT_W)-1:0] s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [NUM_CH*PS_W-1:0]    ps_val,
  output logic [NUM_CH*VAT_W-1:0]   vat_val,
  output logic                      vm_update,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow,
  output logic                      underflow,
  output logic [15:0]               underflow_count
);

  localparam int c_ent_w  = PS_W + VAT_W;
  localparam int c_dw     = NUM_CH * c_ent_w;
  localparam int c_addr_w = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_GAP = 2'd2} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         fast_cnt_q, fast_cnt_d, gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]         col_q, col_d, row_q, row_d, pass_q, pass_d;
  logic [c_addr_w-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_addr_w:0]        fill_q, fill_d;
  logic [NUM_CH*PS_W-1:0]   ps_q, ps_d;
  logic [NUM_CH*VAT_W-1:0]  vat_q, vat_d;
  logic                     vm_update_q, vm_update_d, done_q, done_d;
  logic                     overflow_q, overflow_d, underflow_q, underflow_d;
  logic [c_dw-1:0]          mem_q [FIFO_DEPTH];

  logic            w_full, w_empty, w_tick, w_pop, w_wr, w_apply, w_uf_tick, w_start_ok;
  logic [c_dw-1:0] w_entry;

  // fill_q MSB alone marks "full" because the depth is a power of two
  assign w_full     = fill_q[c_addr_w];
  assign w_empty    = (fill_q == '0);
  assign w_tick     = (state_q == S_ACTIVE) && (fast_cnt_q == fast_clk_div);
  assign w_pop      = w_tick && !w_empty;
  assign w_uf_tick  = w_tick && w_empty;
  assign w_wr       = s_valid && (!w_full || w_pop) && !ctrl_rst;
  assign w_apply    = w_pop && (col_q < row_valid_length) && (col_q < row_length);
  assign w_start_ok = (pulse_cnt != '0) && (file_length != '0) && (row_length != '0);
  assign w_entry    = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    fast_cnt_d  = fast_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    col_d       = col_q;
    row_d       = row_q;
    pass_d      = pass_q;
    wr_ptr_d    = w_wr  ? wr_ptr_q + c_addr_w'(1) : wr_ptr_q;
    rd_ptr_d    = w_pop ? rd_ptr_q + c_addr_w'(1) : rd_ptr_q;
    fill_d      = fill_q;
    if (w_wr && !w_pop)      fill_d = fill_q + (c_addr_w+1)'(1);
    else if (!w_wr && w_pop) fill_d = fill_q - (c_addr_w+1)'(1);
    ps_d        = ps_q;
    vat_d       = vat_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q | (s_valid & ~w_wr);
    underflow_d = underflow_q | w_uf_tick;

    case (state_q)
      S_IDLE: begin
        if (start && w_start_ok) begin
          state_d    = S_ACTIVE;
          fast_cnt_d = '0;
          col_d      = '0;
          row_d      = '0;
          pass_d     = '0;
        end
      end
      S_ACTIVE: begin
        fast_cnt_d = w_tick ? '0 : fast_cnt_q + CNT_W'(1);
        if (w_pop) begin
          if (col_q == row_length - CNT_W'(1)) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
            col_d     = '0;
          end else begin
            col_d = col_q + CNT_W'(1);
          end
        end
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q + CNT_W'(1);
        if (gap_cnt_q == slow_clk_div) begin
          fast_cnt_d = '0;
          state_d    = S_ACTIVE;
          if (row_q != file_length - CNT_W'(1)) begin
            row_d = row_q + CNT_W'(1);
          end else if (pass_q != pulse_cnt - CNT_W'(1)) begin
            row_d  = '0;
            pass_d = pass_q + CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Idle forcing keys off the next state so it lands together with GAP/IDLE entry
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_apply && active_modes[c]) begin
        ps_d[c*PS_W +: PS_W]   = w_entry[c*c_ent_w +: PS_W];
        vat_d[c*VAT_W +: VAT_W] = w_entry[c*c_ent_w+PS_W +: VAT_W];
      end
      if ((state_d != S_ACTIVE) || !active_modes[c]) begin
        if (phase_idle_modes[c]) ps_d[c*PS_W +: PS_W] = '0;
        if (atten_idle_modes[c]) vat_d[c*VAT_W +: VAT_W] = '1;
      end
    end
    vm_update_d = w_apply || (ps_d != ps_q) || (vat_d != vat_q);

    if (ctrl_rst) begin
      state_d     = S_IDLE;
      fast_cnt_d  = '0;
      gap_cnt_d   = '0;
      col_d       = '0;
      row_d       = '0;
      pass_d      = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fill_d      = '0;
      ps_d        = '0;
      vat_d       = '1;
      vm_update_d = 1'b0;
      done_d      = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      fast_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pass_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      ps_q        <= '0;
      vat_q       <= '1;
      vm_update_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fast_cnt_q  <= fast_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pass_q      <= pass_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      ps_q        <= ps_d;
      vat_q       <= vat_d;
      vm_update_q <= vm_update_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) mem_q[wr_ptr_q] <= s_data;
  end

`ifdef VM_UNDERFLOW_COUNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (ctrl_rst)                            ucnt_d = '0;
    else if (w_uf_tick && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ucnt_q <= '0;
    else     ucnt_q <= ucnt_d;
  end

  assign underflow_count = ucnt_q;
`else
  assign underflow_count = '0;
`endif

  assign s_ready   = ~w_full;
  assign ps_val    = ps_q;
  assign vat_val   = vat_q;
  assign vm_update = vm_update_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vm_mask_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_vm_mask_sequencer
// Desc     : Self-checking bench for vm_mask_sequencer (2 channels, 16-deep FIFO).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vm_mask_sequencer;
  localparam int NUM_CH = 2;
  localparam int PS_W   = 6;
  localparam int VAT_W  = 6;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int c_dw   = NUM_CH * (PS_W + VAT_W);

  logic clk = 1'b0, rst = 1'b1, ctrl_rst = 1'b0, start = 1'b0;
  logic [CNT_W-1:0] fast_clk_div = '0, slow_clk_div = '0, pulse_cnt = '0;
  logic [CNT_W-1:0] row_length = '0, row_valid_length = '0, file_length = '0;
  logic [NUM_CH-1:0] active_modes = '0, phase_idle_modes = '0, atten_idle_modes = '0;
  logic [c_dw-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic s_ready, vm_update, busy, done, overflow, underflow;
  logic [NUM_CH*PS_W-1:0]  ps_val;
  logic [NUM_CH*VAT_W-1:0] vat_val;
  logic [15:0] underflow_count;

  vm_mask_sequencer #(.NUM_CH(NUM_CH), .PS_W(PS_W), .VAT_W(VAT_W),
                      .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ctrl_rst(ctrl_rst), .start(start),
    .fast_clk_div(fast_clk_div), .slow_clk_div(slow_clk_div), .pulse_cnt(pulse_cnt),
    .row_length(row_length), .row_valid_length(row_valid_length), .file_length(file_length),
    .active_modes(active_modes), .phase_idle_modes(phase_idle_modes),
    .atten_idle_modes(atten_idle_modes), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ps_val(ps_val), .vat_val(vat_val), .vm_update(vm_update),
    .busy(busy), .done(done), .overflow(overflow), .underflow(underflow),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int f, s, len, vl, fl, pc;
  logic [c_dw-1:0] ent[$];

  typedef struct {
    int f, s, len, vl, fl, pc;
    logic [1:0] act, pim, aim;
    int exp_upd, exp_done;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [c_dw-1:0] mk_ent(input int i);
    logic [c_dw-1:0] e;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e[c*12 +: 6]     = 6'(i + 1 + 16*c);
      e[c*12 + 6 +: 6] = 6'(i + 2 + 16*c);
    end
    return e;
  endfunction

  function automatic int exp_ucnt(input int v);
`ifdef VM_UNDERFLOW_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic soft_reset();
    s_valid = 1'b0; start = 1'b0; ctrl_rst = 1'b1;
    @(negedge clk);
    ctrl_rst = 1'b0;
  endtask

  task automatic push(input logic [c_dw-1:0] d);
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic apply_cfg();
    fast_clk_div = 16'(f); slow_clk_div = 16'(s); row_length = 16'(len);
    row_valid_length = 16'(vl); file_length = 16'(fl); pulse_cnt = 16'(pc);
  endtask

  // Reference: row period P = len*(f+1) + s + 1; tick k of row g lands at offset (k+1)*(f+1).
  task automatic run_model(input int max_n, output int upd, output int done_n);
    logic [NUM_CH*PS_W-1:0]  eps, nps;
    logic [NUM_CH*VAT_W-1:0] evat, nvat;
    logic [c_dw-1:0] e;
    logic e_upd, applied, last;
    logic [26:0] exp_v, got_v;
    int R, P, m, g, w, k;
    eps = '0; evat = '1; upd = 0; done_n = 0;
    R = (pc != 0 && fl != 0 && len != 0) ? fl * pc : 0;
    P = len * (f + 1) + s + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= max_n; n++) begin
      m = n - 1; e_upd = 1'b0; nps = eps; nvat = evat;
      if (m < R * P) begin
        g = m / P; w = m % P;
        if (w > 0 && w <= len * (f + 1) && (w % (f + 1)) == 0) begin
          k = w / (f + 1) - 1;
          e = ent[g * len + k];
          applied = (k < vl);
          last = (k == len - 1);
          for (int c = 0; c < NUM_CH; c++) begin
            if (applied && active_modes[c]) begin
              nps[c*6 +: 6]  = e[c*12 +: 6];
              nvat[c*6 +: 6] = e[c*12 + 6 +: 6];
            end
            if (last || !active_modes[c]) begin
              if (phase_idle_modes[c]) nps[c*6 +: 6] = '0;
              if (atten_idle_modes[c]) nvat[c*6 +: 6] = '1;
            end
          end
          e_upd = applied || (nps != eps) || (nvat != evat);
        end
      end
      eps = nps; evat = nvat;
      exp_v = {(n < 1 + R * P), (R > 0 && n == 1 + R * P), e_upd, eps, evat};
      got_v = {busy, done, vm_update, ps_val, vat_val};
      check($sformatf("cycle n=%0d {busy,done,upd,ps,vat}", n), 32'(got_v), 32'(exp_v));
      if (vm_update) upd++;
      if (done && done_n == 0) done_n = n;
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[9];
    int upd, dn, nent, R, P, seen;

    tbl[0] = '{3, 7, 4, 3, 2, 1, 2'b11, 2'b00, 2'b00, 6, 49};
    tbl[1] = '{0, 0, 1, 1, 3, 2, 2'b11, 2'b00, 2'b00, 6, 13};
    tbl[2] = '{1, 2, 3, 5, 1, 1, 2'b11, 2'b00, 2'b00, 3, 10};
    tbl[3] = '{2, 1, 2, 0, 2, 1, 2'b11, 2'b00, 2'b00, 0, 17};
    tbl[4] = '{1, 1, 2, 2, 1, 0, 2'b11, 2'b00, 2'b00, 0, 0};
    tbl[5] = '{1, 1, 2, 2, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0};
    tbl[6] = '{1, 1, 0, 2, 1, 1, 2'b11, 2'b00, 2'b00, 0, 0};
    tbl[7] = '{3, 7, 4, 3, 2, 1, 2'b01, 2'b00, 2'b10, 6, 49};
    tbl[8] = '{1, 1, 2, 1, 1, 1, 2'b11, 2'b11, 2'b11, 2, 7};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ps_val", 32'(ps_val), 32'h0);
    check("reset vat_val", 32'(vat_val), 32'hFFF);
    check("reset vm_update/busy/done", 32'({vm_update, busy, done}), 32'h0);
    check("reset overflow/underflow", 32'({overflow, underflow}), 32'h0);
    check("reset underflow_count", 32'(underflow_count), 32'h0);
    check("reset s_ready", 32'(s_ready), 32'h1);

    // Table-driven configurations
    for (int i = 0; i < 9; i++) begin
      soft_reset();
      f = tbl[i].f; s = tbl[i].s; len = tbl[i].len; vl = tbl[i].vl;
      fl = tbl[i].fl; pc = tbl[i].pc;
      apply_cfg();
      active_modes = tbl[i].act; phase_idle_modes = tbl[i].pim; atten_idle_modes = tbl[i].aim;
      R = (pc != 0 && fl != 0 && len != 0) ? fl * pc : 0;
      P = len * (f + 1) + s + 1;
      nent = R * len;
      ent.delete();
      for (int j = 0; j < nent; j++) begin
        ent.push_back(mk_ent(j));
        push(mk_ent(j));
      end
      run_model((R > 0) ? R * P + 4 : 12, upd, dn);
      check($sformatf("tbl%0d update count", i), 32'(upd), 32'(tbl[i].exp_upd));
      check($sformatf("tbl%0d done cycle", i), 32'(dn), 32'(tbl[i].exp_done));
      check($sformatf("tbl%0d ovf/unf", i), 32'({overflow, underflow}), 32'h0);
    end

    // Randomized configurations against the reference model
    for (int i = 0; i < 25; i++) begin
      soft_reset();
      f = $urandom_range(0, 3); s = $urandom_range(0, 4); len = $urandom_range(1, 4);
      vl = $urandom_range(0, 5); fl = $urandom_range(1, 2); pc = $urandom_range(1, 2);
      apply_cfg();
      active_modes = 2'($urandom); phase_idle_modes = 2'($urandom); atten_idle_modes = 2'($urandom);
      R = fl * pc;
      P = len * (f + 1) + s + 1;
      ent.delete();
      for (int j = 0; j < R * len; j++) begin
        ent.push_back(c_dw'($urandom));
        push(ent[j]);
      end
      run_model(R * P + 4, upd, dn);
      check($sformatf("rand%0d done cycle", i), 32'(dn), 32'(1 + R * P));
      check($sformatf("rand%0d ovf/unf", i), 32'({overflow, underflow}), 32'h0);
    end

    // Underflow: 5 entries for an 8-pop file, 3 more pushed while stalled
    soft_reset();
    f = 3; s = 7; len = 4; vl = 3; fl = 2; pc = 1;
    apply_cfg();
    active_modes = 2'b11; phase_idle_modes = 2'b00; atten_idle_modes = 2'b00;
    for (int j = 0; j < 5; j++) push(mk_ent(j));
    upd = 0; dn = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      if (n == 32) check("underflow before empty tick", 32'(underflow), 32'h0);
      if (n == 33) check("underflow after empty tick", 32'(underflow), 32'h1);
      if (n == 33 || n == 37 || n == 41)
        check($sformatf("underflow_count n=%0d", n), 32'(underflow_count), 32'(exp_ucnt((n - 29) / 4)));
      if (vm_update) upd++;
      if (done && dn == 0) dn = n;
      if (n >= 42 && n <= 44) begin
        s_valid = 1'b1; s_data = mk_ent(n - 37);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    check("underflow run update count", 32'(upd), 32'd6);
    check("underflow run done cycle", 32'(dn), 32'd61);
    check("underflow run overflow", 32'(overflow), 32'h0);
    check("underflow run final count", 32'(underflow_count), 32'(exp_ucnt(3)));
    soft_reset();
    check("underflow cleared by ctrl_rst", 32'({underflow, underflow_count}), 32'h0);

    // Overflow: 17 writes into an empty idle FIFO
    soft_reset();
    s_valid = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      s_data = mk_ent(i);
      @(negedge clk);
      if (i == 15) check("s_ready after 15 writes", 32'(s_ready), 32'h1);
      if (i == 16) check("s_ready/overflow after 16 writes", 32'({s_ready, overflow}), 32'h0);
      if (i == 17) check("overflow after 17th write", 32'(overflow), 32'h1);
    end
    s_valid = 1'b0;
    soft_reset();
    check("overflow cleared by ctrl_rst", 32'({overflow, s_ready}), 32'h1);

    // ctrl_rst mid-row
    f = 3; s = 7; len = 4; vl = 3; fl = 2; pc = 1;
    apply_cfg();
    active_modes = 2'b11;
    for (int j = 0; j < 8; j++) push(mk_ent(j));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    ctrl_rst = 1'b1;
    @(negedge clk);
    ctrl_rst = 1'b0;
    check("ctrl_rst busy/done/upd", 32'({busy, done, vm_update}), 32'h0);
    check("ctrl_rst ps_val", 32'(ps_val), 32'h0);
    check("ctrl_rst vat_val", 32'(vat_val), 32'hFFF);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("no busy/done after ctrl_rst", 32'(seen), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      push(mk_ent(i));
      if (i == 15) check("flushed FIFO: s_ready after 15", 32'(s_ready), 32'h1);
      if (i == 16) check("flushed FIFO: s_ready after 16", 32'(s_ready), 32'h0);
    end
    soft_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
